timer_bus_arbiter: RTL and testbench
====================================

Name: timer_bus_arbiter

Overview:
Round-robin arbiter that shares the single memory-mapped timer bus port between NumHosts requesters, for example the core data port and a debug/DMA host. It allows one outstanding transaction at a time and routes the response (rvalid/rdata/err) back to the granted host. A watchdog counter returns an error to the host if the device does not answer. It sits between the host-side bus fabric and the timer's req/addr/we/be/wdata/rvalid/rdata/err port.

Parameters:
NumHosts, 2, number of requesters (2..8)
DataWidth, 32, bus data width (must be 32)
AddressWidth, 32, bus address width
TimeoutCycles, 15, cycles spent in WAIT without device rvalid before an error response is generated (>=2)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
host_req_i  input  NumHosts  per-host request
host_gnt_o  output  NumHosts  per-host grant (one-hot or zero)
host_addr_i  input  NumHosts*AddressWidth  per-host address
host_we_i  input  NumHosts  per-host write enable
host_be_i  input  NumHosts*DataWidth/8  per-host byte enables
host_wdata_i  input  NumHosts*DataWidth  per-host write data
host_rvalid_o  output  NumHosts  per-host response valid (one-hot or zero)
host_rdata_o  output  DataWidth  response data, broadcast to all hosts
host_err_o  output  1  response error, qualified by host_rvalid_o
timer_req_o  output  1  device request
timer_addr_o  output  AddressWidth  device address
timer_we_o  output  1  device write enable
timer_be_o  output  DataWidth/8  device byte enables
timer_wdata_o  output  DataWidth  device write data
timer_rvalid_i  input  1  device response valid
timer_rdata_i  input  DataWidth  device read data
timer_err_i  input  1  device error

Behaviour:
- Reset (synchronous, rst_i high at a clk_i edge): state <= IDLE; rr_ptr <= 0; gnt_idx <= 0; timeout counter <= 0. While rst_i is high, all outputs are forced to 0 (gnt, rvalid, timer_req_o, host_err_o, host_rdata_o, timer_* outputs).
- Host protocol: a host holds req and its attributes stable until it sees gnt. Exactly one response (host_rvalid_o bit) follows each grant.
- Arbitration is enabled when state==IDLE, or when state==WAIT and timer_rvalid_i==1 (back-to-back operation).
  - When enabled, the winner is the first requesting host scanning from rr_ptr upward, modulo NumHosts.
  - host_gnt_o[winner]=1 in the same cycle (combinational).
  - timer_req_o=1 with the winner's addr/we/be/wdata muxed through combinationally.
  - On that edge: gnt_idx <= winner; rr_ptr <= (winner+1) mod NumHosts; state <= WAIT; counter <= 0.
- When arbitration is disabled, or no host requests: gnt=0, timer_req_o=0, timer_addr/be/wdata/we driven 0.
- WAIT state:
  - timer_rvalid_i=1 gives host_rvalid_o[gnt_idx]=1, host_rdata_o=timer_rdata_i, host_err_o=timer_err_i, all in the same cycle. Next state is WAIT if a new grant is made that cycle, else IDLE.
  - Otherwise the counter increments. If the counter reaches TimeoutCycles-1: host_rvalid_o[gnt_idx]=1, host_err_o=1, host_rdata_o=0; state <= IDLE.
- timer_rvalid_i in IDLE (stray or late response after a timeout) is ignored: no host_rvalid_o.
- Throughput: with the timer's fixed 1-cycle latency, one transaction per cycle is possible while requests remain pending. Requester latency from gnt to rvalid is 1 cycle.
- Reset mid-transaction: the in-flight response is dropped; no rvalid is generated for it.
- Counter width is $clog2(TimeoutCycles). It never wraps because it clears on every exit from WAIT.
- Invariants:
  - host_gnt_o and host_rvalid_o are each at most one-hot.
  - timer_req_o == |host_gnt_o.

Test Plan:
- Single host 0 read of addr 0x0 at reset: gnt[0] in cycle 0; rvalid[0] in cycle 1 with rdata=timer_rdata_i; no activity on host 1.
- Hosts 0 and 1 both request continuously for 4 transactions: grants go 0,1,0,1 on consecutive cycles; each rvalid lands on the previously granted host; no idle cycles.
- Host 1 write be=4'b0011 wdata=0x1234_5678 to 0x8: timer_* outputs exactly mirror host 1 fields in the grant cycle; the response is routed to host 1 only.
- Device held silent (rvalid_i=0) after a grant to host 0 with TimeoutCycles=15: host_rvalid_o[0]=1, host_err_o=1 exactly 15 cycles after the grant; a late rvalid_i afterwards produces no host response.
- Device returns err_i=1 for addr 0x10: host_err_o=1 with rvalid to the granted host.
- rst_i asserted in the WAIT cycle with rvalid_i=1: no host_rvalid_o; after reset, a next request from hosts 0 and 1 grants host 0 (rr_ptr=0).

Source files
------------

// File: rtl/timer_bus_arbiter_if.sv
// Host-side and device-side bus bundle for the timer bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric and device.
interface timer_bus_arbiter_if #(
   parameter int NumHosts     = 2,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);
   logic [NumHosts-1:0]                host_req_i;
   logic [NumHosts-1:0]                host_gnt_o;
   logic [NumHosts*AddressWidth-1:0]   host_addr_i;
   logic [NumHosts-1:0]                host_we_i;
   logic [NumHosts*DataWidth/8-1:0]    host_be_i;
   logic [NumHosts*DataWidth-1:0]      host_wdata_i;
   logic [NumHosts-1:0]                host_rvalid_o;
   logic [DataWidth-1:0]               host_rdata_o;
   logic                               host_err_o;

   logic                               timer_req_o;
   logic [AddressWidth-1:0]            timer_addr_o;
   logic                               timer_we_o;
   logic [DataWidth/8-1:0]             timer_be_o;
   logic [DataWidth-1:0]               timer_wdata_o;
   logic                               timer_rvalid_i;
   logic [DataWidth-1:0]               timer_rdata_i;
   logic                               timer_err_i;

   modport slave (
      input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      input  timer_rvalid_i, timer_rdata_i, timer_err_i,
      output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      output timer_req_o, timer_addr_o, timer_we_o, timer_be_o, timer_wdata_o
   );

   modport master (
      output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      output timer_rvalid_i, timer_rdata_i, timer_err_i,
      input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      input  timer_req_o, timer_addr_o, timer_we_o, timer_be_o, timer_wdata_o
   );
endinterface

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing one timer bus port among NumHosts requesters,
// one outstanding transaction, with a watchdog error response.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | nothing outstanding; a request is granted immediately
//   ST_WAIT  | one transaction outstanding for gnt_idx_q; watchdog running
module timer_bus_arbiter #(
   parameter int NumHosts      = 2,
   parameter int DataWidth     = 32,
   parameter int AddressWidth  = 32,
   parameter int TimeoutCycles = 15
) (
   input  logic               clk_i,
   input  logic               rst_i,
   timer_bus_arbiter_if.slave bus
);
   localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
   localparam int CntW = $clog2(TimeoutCycles);
   localparam int BeW  = DataWidth / 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [IdxW-1:0] cand;
   logic [IdxW-1:0] winner;
   logic            win_vld;
   logic            arb_en;
   logic            grant;
   logic            timeout;
   logic            rsp;

   logic [NumHosts-1:0]     gnt_oh;
   logic [NumHosts-1:0]     rvalid_oh;
   logic [AddressWidth-1:0] mux_addr;
   logic                    mux_we;
   logic [BeW-1:0]          mux_be;
   logic [DataWidth-1:0]    mux_wdata;

   // First requester at or after rr_ptr_q, wrapping modulo NumHosts.
   always_comb begin
      cand    = '0;
      winner  = '0;
      win_vld = 1'b0;
      for (int i = 0; i < NumHosts; i++) begin
         cand = IdxW'((int'(rr_ptr_q) + i) % NumHosts);
         if (!win_vld && bus.host_req_i[cand]) begin
            win_vld = 1'b1;
            winner  = cand;
         end
      end
   end

   assign arb_en  = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && bus.timer_rvalid_i);
   assign grant   = arb_en && win_vld && !rst_i;
   assign timeout = (state_q == ST_WAIT) && !bus.timer_rvalid_i &&
                    (cnt_q == CntW'(TimeoutCycles - 1));
   assign rsp     = (state_q == ST_WAIT) && (bus.timer_rvalid_i || timeout) && !rst_i;

   always_comb begin
      gnt_oh    = '0;
      rvalid_oh = '0;
      mux_addr  = '0;
      mux_we    = 1'b0;
      mux_be    = '0;
      mux_wdata = '0;
      for (int h = 0; h < NumHosts; h++) begin
         if (grant && (IdxW'(h) == winner)) begin
            gnt_oh[h] = 1'b1;
            mux_addr  = bus.host_addr_i[h*AddressWidth +: AddressWidth];
            mux_we    = bus.host_we_i[h];
            mux_be    = bus.host_be_i[h*BeW +: BeW];
            mux_wdata = bus.host_wdata_i[h*DataWidth +: DataWidth];
         end
         if (rsp && (IdxW'(h) == gnt_idx_q)) begin
            rvalid_oh[h] = 1'b1;
         end
      end
   end

   assign bus.host_gnt_o    = gnt_oh;
   assign bus.timer_req_o   = grant;
   assign bus.timer_addr_o  = mux_addr;
   assign bus.timer_we_o    = mux_we;
   assign bus.timer_be_o    = mux_be;
   assign bus.timer_wdata_o = mux_wdata;
   assign bus.host_rvalid_o = rvalid_oh;
   // A watchdog response carries zero data and a forced error.
   assign bus.host_rdata_o  = (rsp && bus.timer_rvalid_i) ? bus.timer_rdata_i : '0;
   assign bus.host_err_o    = rsp && (bus.timer_rvalid_i ? bus.timer_err_i : 1'b1);

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_idx_d = gnt_idx_q;
      cnt_d     = cnt_q;
      if (grant) begin
         state_d   = ST_WAIT;
         gnt_idx_d = winner;
         rr_ptr_d  = IdxW'((int'(winner) + 1) % NumHosts);
         cnt_d     = '0;
      end else if (state_q == ST_WAIT) begin
         if (bus.timer_rvalid_i || timeout) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         gnt_idx_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_idx_q <= gnt_idx_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Directed bench for timer_bus_arbiter: a transaction-level model predicts every
// output each cycle, with literal pins on grant order, field routing and watchdog timing.
module tb_timer_bus_arbiter;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BW = DW / 8;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   timer_bus_arbiter_if #(.NumHosts(N), .DataWidth(DW), .AddressWidth(AW)) bus ();

   timer_bus_arbiter #(
      .NumHosts(N), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   int            pend [N];
   logic [AW-1:0] haddr[N];
   logic          hwe  [N];
   logic [BW-1:0] hbe  [N];
   logic [DW-1:0] hwd  [N];

   // Model: is a transaction outstanding, for whom, how many cycles it has waited.
   bit            m_busy;
   int            m_owner;
   int            m_waited;
   int            m_ptr;
   logic [AW-1:0] m_oaddr;

   bit dev_silent;
   bit dev_force;

   int gnt_log[$];
   int gnt_cyc[$];
   int rsp_cyc[$];

   logic [N-1:0]  cap_gnt, cap_rv;
   logic          cap_req, cap_we, cap_err;
   logic [AW-1:0] cap_addr;
   logic [BW-1:0] cap_be;
   logic [DW-1:0] cap_wdata, cap_rdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic drive();
      logic rv;
      for (int h = 0; h < N; h++) begin
         bus.host_req_i[h]              = (pend[h] > 0);
         bus.host_addr_i[h*AW +: AW]    = haddr[h];
         bus.host_we_i[h]               = hwe[h];
         bus.host_be_i[h*BW +: BW]      = hbe[h];
         bus.host_wdata_i[h*DW +: DW]   = hwd[h];
      end
      rv = (m_busy && m_waited == 1 && !dev_silent) || dev_force;
      bus.timer_rvalid_i = rv;
      bus.timer_rdata_i  = rv ? (m_busy ? (m_oaddr ^ 32'h5A5A_0000) : 32'hCAFE_F00D) : 32'hFFFF_FFFF;
      bus.timer_err_i    = rv && m_busy && (m_oaddr == 32'h10);
   endtask

   task automatic tick();
      int            win, hh;
      bit            do_gnt, do_rsp;
      logic [N-1:0]  e_gnt, e_rv;
      logic [AW-1:0] e_addr;
      logic [BW-1:0] e_be;
      logic [DW-1:0] e_wdata, e_rdata;
      logic          e_we, e_err;
      drive();
      #3;
      win = -1;
      if (!rst && (!m_busy || bus.timer_rvalid_i)) begin
         for (int k = 0; k < N; k++) begin
            hh = (m_ptr + k) % N;
            if (win < 0 && pend[hh] > 0) win = hh;
         end
      end
      do_gnt  = (win >= 0);
      do_rsp  = !rst && m_busy && (bus.timer_rvalid_i || m_waited == TO);
      e_gnt   = do_gnt ? (N'(1) << win) : '0;
      e_addr  = do_gnt ? haddr[win] : '0;
      e_we    = do_gnt ? hwe[win] : 1'b0;
      e_be    = do_gnt ? hbe[win] : '0;
      e_wdata = do_gnt ? hwd[win] : '0;
      e_rv    = do_rsp ? (N'(1) << m_owner) : '0;
      e_rdata = (do_rsp && bus.timer_rvalid_i) ? bus.timer_rdata_i : '0;
      e_err   = do_rsp && (bus.timer_rvalid_i ? bus.timer_err_i : 1'b1);

      chk("gnt",    bus.host_gnt_o,    e_gnt);
      chk("req",    bus.timer_req_o,   do_gnt);
      chk("addr",   bus.timer_addr_o,  e_addr);
      chk("we",     bus.timer_we_o,    e_we);
      chk("be",     bus.timer_be_o,    e_be);
      chk("wdata",  bus.timer_wdata_o, e_wdata);
      chk("rvalid", bus.host_rvalid_o, e_rv);
      chk("rdata",  bus.host_rdata_o,  e_rdata);
      chk("err",    bus.host_err_o,    e_err);

      cap_gnt = bus.host_gnt_o;   cap_req   = bus.timer_req_o;
      cap_addr = bus.timer_addr_o; cap_we   = bus.timer_we_o;
      cap_be  = bus.timer_be_o;   cap_wdata = bus.timer_wdata_o;
      cap_rv  = bus.host_rvalid_o; cap_rdata = bus.host_rdata_o;
      cap_err = bus.host_err_o;

      if (do_gnt) begin gnt_log.push_back(win); gnt_cyc.push_back(cyc); end
      if (do_rsp) rsp_cyc.push_back(cyc);

      @(posedge clk);
      cyc++;
      if (rst) begin
         m_busy = 0; m_ptr = 0; m_waited = 0;
      end else if (do_gnt) begin
         m_busy = 1; m_owner = win; m_oaddr = haddr[win]; m_waited = 1;
         m_ptr = (win + 1) % N;
         pend[win]--; haddr[win] += 4; hwd[win] += 1;
      end else if (do_rsp) begin
         m_busy = 0; m_waited = 0;
      end else if (m_busy) begin
         m_waited++;
      end
      #1;
   endtask

   task automatic set_host(input int h, input int n, input logic [AW-1:0] a,
                           input logic we, input logic [BW-1:0] be, input logic [DW-1:0] wd);
      pend[h] = n; haddr[h] = a; hwe[h] = we; hbe[h] = be; hwd[h] = wd;
   endtask

   int base;

   initial begin
      for (int h = 0; h < N; h++) set_host(h, 0, '0, 1'b0, '0, '0);
      m_busy = 0; m_owner = 0; m_waited = 0; m_ptr = 0; m_oaddr = '0;
      dev_silent = 0; dev_force = 0;
      rst = 1'b1;
      #1;
      tick();
      dev_force = 1;
      set_host(0, 1, 32'h0, 1'b0, 4'hF, 32'h0);
      tick();
      chk("rst_forces_zero", {cap_gnt, cap_req, cap_rv, cap_err}, '0);
      dev_force = 0;
      rst = 1'b0;

      // Single host 0 read of address 0
      tick();
      chk("t1_gnt", cap_gnt, 2'b01);
      tick();
      chk("t1_rv", cap_rv, 2'b01);
      chk("t1_rdata", cap_rdata, 32'h5A5A_0000);
      tick();

      // Back-to-back from both hosts after a fresh reset
      rst = 1'b1; tick(); rst = 1'b0;
      set_host(0, 2, 32'h100, 1'b0, 4'hF, 32'h0);
      set_host(1, 2, 32'h200, 1'b0, 4'hF, 32'h0);
      base = gnt_log.size();
      for (int i = 0; i < 6; i++) tick();
      chk("t2_n", gnt_log.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t2_order", gnt_log[base+i], i % 2);
         if (i > 0) chk("t2_no_idle", gnt_cyc[base+i] - gnt_cyc[base+i-1], 1);
      end

      // Host 1 write
      set_host(1, 1, 32'h8, 1'b1, 4'b0011, 32'h1234_5678);
      tick();
      chk("t3_gnt", cap_gnt, 2'b10);
      chk("t3_fields", {cap_req, cap_we, cap_be, cap_addr, cap_wdata},
          {1'b1, 1'b1, 4'b0011, 32'h8, 32'h1234_5678});
      tick();
      chk("t3_rv", cap_rv, 2'b10);
      tick();

      // Silent device: watchdog then stray late response
      dev_silent = 1;
      set_host(0, 1, 32'h20, 1'b0, 4'hF, 32'h0);
      tick();
      chk("t4_gnt", cap_gnt, 2'b01);
      for (int i = 0; i < TO; i++) tick();
      chk("t4_rv", cap_rv, 2'b01);
      chk("t4_err", cap_err, 1'b1);
      chk("t4_rdata", cap_rdata, 32'h0);
      chk("t4_delay", rsp_cyc[rsp_cyc.size()-1] - gnt_cyc[gnt_cyc.size()-1], TO);
      dev_silent = 0;
      dev_force = 1;
      tick();
      chk("t4_stray", cap_rv, 2'b00);
      dev_force = 0;

      // Device error
      set_host(0, 1, 32'h10, 1'b0, 4'hF, 32'h0);
      tick();
      tick();
      chk("t5_rv", cap_rv, 2'b01);
      chk("t5_err", cap_err, 1'b1);
      tick();

      // Reset while a response is arriving
      set_host(0, 1, 32'h40, 1'b0, 4'hF, 32'h0);
      tick();
      rst = 1'b1;
      tick();
      chk("t6_drop", cap_rv, 2'b00);
      rst = 1'b0;
      set_host(0, 1, 32'h44, 1'b0, 4'hF, 32'h0);
      set_host(1, 1, 32'h48, 1'b0, 4'hF, 32'h0);
      tick();
      chk("t6_gnt", cap_gnt, 2'b01);
      for (int i = 0; i < 4; i++) tick();
      chk("t6_drain", pend[0] + pend[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
